// File: rtl/lobster_pkg.sv
// Shared definitions for the data-bus arbiter: port indices, FSM state encoding
// and small port-index helpers.
package lobster_pkg;

  localparam int NUM_PORTS = 3;

  localparam logic [1:0] PORT_FETCH = 2'd0;
  localparam logic [1:0] PORT_LOAD  = 2'd1;
  localparam logic [1:0] PORT_STORE = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } arb_state_t;

  function automatic logic [1:0] port_idx(input logic [2:0] onehot);
    port_idx = onehot[2] ? PORT_STORE : (onehot[1] ? PORT_LOAD : PORT_FETCH);
  endfunction

  // Port following p in round-robin order, wrapping store back to fetch.
  function automatic logic [1:0] port_next(input logic [1:0] p);
    port_next = (p == PORT_STORE) ? PORT_FETCH : p + 2'd1;
  endfunction

endpackage

// File: rtl/lobster_dbus_arbiter_if.sv
// Requester + SRAM bundle of the data-bus arbiter. The arbiter uses the slave
// view; the environment (requesters and SRAM model) uses the master view.
interface lobster_dbus_arbiter_if #(
  parameter int ADDR_WIDTH = 36
);
  logic [2:0]            req;
  logic [ADDR_WIDTH-1:0] addr_f;
  logic [ADDR_WIDTH-1:0] addr_l;
  logic [ADDR_WIDTH-1:0] addr_s;
  logic [63:0]           wdata_s;
  logic [2:0]            done;
  logic                  err;
  logic [63:0]           rdata;
  logic                  ce;
  logic                  we;
  logic [ADDR_WIDTH-1:0] addr_in;
  logic [ADDR_WIDTH-1:0] addr_out;
  logic [63:0]           data_out;
  logic [63:0]           data_in;
  logic                  rdy;

  modport slave (
    input  req, addr_f, addr_l, addr_s, wdata_s, data_in, rdy,
    output done, err, rdata, ce, we, addr_in, addr_out, data_out
  );

  modport master (
    output req, addr_f, addr_l, addr_s, wdata_s, data_in, rdy,
    input  done, err, rdata, ce, we, addr_in, addr_out, data_out
  );
endinterface

// File: rtl/lobster_dbus_pick.sv
// Combinational winner select: scans the request vector starting at i_ptr,
// ascending (round-robin) or descending (fixed store > load > fetch).
module lobster_dbus_pick
  import lobster_pkg::*;
#(
  parameter bit DESCEND = 1'b0
) (
  input  logic [2:0] i_req,
  input  logic [1:0] i_ptr,
  output logic [2:0] o_grant
);

  logic       w_found;
  logic [2:0] w_idx;

  always_comb begin
    o_grant = '0;
    w_found = 1'b0;
    w_idx   = '0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      if (DESCEND) w_idx = {1'b0, i_ptr} + 3'd3 - 3'(k);
      else         w_idx = {1'b0, i_ptr} + 3'(k);
      if (w_idx >= 3'd3) w_idx = w_idx - 3'd3;
      if (!w_found && i_req[w_idx[1:0]]) begin
        o_grant[w_idx[1:0]] = 1'b1;
        w_found             = 1'b1;
      end
    end
  end

endmodule

// File: rtl/lobster_dbus_arbiter.sv
// Three-port (fetch/load/store) arbiter onto a single SRAM with WAIT timeout.
// Define LOBSTER_DBUS_RR_EN for round-robin arbitration; default is fixed priority.
module lobster_dbus_arbiter
  import lobster_pkg::*;
#(
  parameter int ADDR_WIDTH = 36,
  parameter int TIMEOUT    = 255
) (
  input logic                    clk,
  input logic                    rst,
  lobster_dbus_arbiter_if.slave  bus
);

  localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT - 1);

  arb_state_t            r_state, w_state_nxt;
  logic [1:0]            r_port, w_port_nxt;
  logic                  r_ce, w_ce_nxt;
  logic                  r_we, w_we_nxt;
  logic [2:0]            r_done, w_done_nxt;
  logic                  r_err, w_err_nxt;
  logic [63:0]           r_rdata, w_rdata_nxt;
  logic [ADDR_WIDTH-1:0] r_addr, w_addr_nxt;
  logic [63:0]           r_dout, w_dout_nxt;
  logic [15:0]           r_cnt, w_cnt_nxt;
  logic                  w_fin;
  logic [1:0]            w_start;
  logic [2:0]            w_grant;
  logic [1:0]            w_win;
  logic [ADDR_WIDTH-1:0] w_win_addr;

`ifdef LOBSTER_DBUS_RR_EN
  localparam bit PICK_DESC = 1'b0;

  // Last completed port; resets to store so the first search starts at fetch.
  logic [1:0] r_last;

  always_ff @(posedge clk) begin
    if (rst)        r_last <= PORT_STORE;
    else if (w_fin) r_last <= r_port;
  end

  assign w_start = port_next(r_last);
`else
  localparam bit PICK_DESC = 1'b1;

  assign w_start = PORT_STORE;
`endif

  lobster_dbus_pick #(.DESCEND(PICK_DESC)) u_pick (
    .i_req   (bus.req),
    .i_ptr   (w_start),
    .o_grant (w_grant)
  );

  assign w_win = port_idx(w_grant);

  always_comb begin
    case (w_win)
      PORT_STORE: w_win_addr = bus.addr_s;
      PORT_LOAD:  w_win_addr = bus.addr_l;
      default:    w_win_addr = bus.addr_f;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_port  <= PORT_FETCH;
      r_ce    <= 1'b0;
      r_we    <= 1'b0;
      r_done  <= '0;
      r_err   <= 1'b0;
      r_rdata <= '0;
      r_addr  <= '0;
      r_dout  <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_port  <= w_port_nxt;
      r_ce    <= w_ce_nxt;
      r_we    <= w_we_nxt;
      r_done  <= w_done_nxt;
      r_err   <= w_err_nxt;
      r_rdata <= w_rdata_nxt;
      r_addr  <= w_addr_nxt;
      r_dout  <= w_dout_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Command outputs are registered so ce/we rise with ISSUE and fall with the
  // done pulse; rdy is only looked at in WAIT.
  always_comb begin
    w_state_nxt = r_state;
    w_port_nxt  = r_port;
    w_ce_nxt    = r_ce;
    w_we_nxt    = r_we;
    w_done_nxt  = '0;
    w_err_nxt   = 1'b0;
    w_rdata_nxt = r_rdata;
    w_addr_nxt  = r_addr;
    w_dout_nxt  = r_dout;
    w_cnt_nxt   = r_cnt;
    w_fin       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (|bus.req) begin
          w_state_nxt = ST_ISSUE;
          w_port_nxt  = w_win;
          w_addr_nxt  = w_win_addr;
          w_dout_nxt  = (w_win == PORT_STORE) ? bus.wdata_s : '0;
          w_ce_nxt    = 1'b1;
          w_we_nxt    = (w_win == PORT_STORE);
        end
      end
      ST_ISSUE: begin
        w_state_nxt = ST_WAIT;
        w_cnt_nxt   = '0;
      end
      ST_WAIT: begin
        if (bus.rdy) begin
          w_fin              = 1'b1;
          w_done_nxt[r_port] = 1'b1;
          if (r_port != PORT_STORE) w_rdata_nxt = bus.data_in;
        end else if (r_cnt == WAIT_LAST) begin
          w_fin              = 1'b1;
          w_done_nxt[r_port] = 1'b1;
          w_err_nxt          = 1'b1;
          w_rdata_nxt        = '0;
        end else begin
          w_cnt_nxt = r_cnt + 16'd1;
        end
        if (w_fin) begin
          w_state_nxt = ST_IDLE;
          w_ce_nxt    = 1'b0;
          w_we_nxt    = 1'b0;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_ce_nxt    = 1'b0;
        w_we_nxt    = 1'b0;
      end
    endcase
  end

  assign bus.ce       = r_ce;
  assign bus.we       = r_we;
  assign bus.done     = r_done;
  assign bus.err      = r_err;
  assign bus.rdata    = r_rdata;
  assign bus.addr_in  = r_addr;
  assign bus.addr_out = r_addr;
  assign bus.data_out = r_dout;

endmodule

// File: tb/tb_lobster_dbus_arbiter.sv
// Directed bench for lobster_dbus_arbiter: transaction-level model checked every
// cycle, plus literal expectations for the documented scenarios.
module tb_lobster_dbus_arbiter;

  localparam int AW = 36;
  localparam int TO = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;

  lobster_dbus_arbiter_if #(.ADDR_WIDTH(AW)) bus ();

  lobster_dbus_arbiter #(.ADDR_WIDTH(AW), .TIMEOUT(TO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Model: a transaction is either absent or has an age (1 = command cycle,
  // n >= 2 = (n-1)th wait cycle).
  bit          m_busy;
  int          m_port, m_age, m_last;
  logic [2:0]  e_done;
  logic        e_err, e_ce, e_we;
  logic [63:0] e_rdata, e_dout;
  logic [AW-1:0] e_addr;
  int          c_pick;

`ifdef LOBSTER_DBUS_RR_EN
  function automatic int m_pick(input logic [2:0] r, input int last);
    for (int k = 1; k <= 3; k++) if (r[(last + k) % 3]) return (last + k) % 3;
    return 0;
  endfunction
  always_comb c_pick = m_pick(bus.req, m_last);
`else
  function automatic int m_pick(input logic [2:0] r);
    for (int p = 2; p >= 0; p--) if (r[p]) return p;
    return 0;
  endfunction
  always_comb c_pick = m_pick(bus.req);
`endif

  always @(posedge clk) begin
    if (rst) begin
      m_busy <= 1'b0; m_age <= 0; m_port <= 0; m_last <= 2;
      e_done <= '0; e_err <= 1'b0; e_ce <= 1'b0; e_we <= 1'b0;
      e_rdata <= '0; e_dout <= '0; e_addr <= '0;
    end else begin
      e_done <= '0;
      e_err  <= 1'b0;
      if (!m_busy) begin
        if (bus.req != 3'b000) begin
          m_port <= c_pick; m_busy <= 1'b1; m_age <= 1;
          e_ce   <= 1'b1;   e_we   <= (c_pick == 2);
          e_addr <= (c_pick == 0) ? bus.addr_f : (c_pick == 1) ? bus.addr_l : bus.addr_s;
          e_dout <= (c_pick == 2) ? bus.wdata_s : 64'd0;
        end
      end else if (m_age == 1) begin
        m_age <= 2;
      end else if (bus.rdy || (m_age - 1 == TO)) begin
        e_done <= 3'(1 << m_port);
        e_err  <= !bus.rdy;
        if (!bus.rdy)         e_rdata <= 64'd0;
        else if (m_port != 2) e_rdata <= bus.data_in;
        m_busy <= 1'b0; e_ce <= 1'b0; e_we <= 1'b0; m_last <= m_port;
      end else begin
        m_age <= m_age + 1;
      end
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Advance one cycle and compare every meaningful output against the model.
  task automatic step();
    @(negedge clk);
    chk("m_done", 64'(bus.done), 64'(e_done));
    chk("m_err",  64'(bus.err),  64'(e_err));
    chk("m_ce",   64'(bus.ce),   64'(e_ce));
    chk("m_we",   64'(bus.we),   64'(e_we));
    if (e_ce) begin
      chk("m_addr_in",  64'(bus.addr_in),  64'(e_addr));
      chk("m_addr_out", 64'(bus.addr_out), 64'(e_addr));
      chk("m_data_out", bus.data_out, e_dout);
    end
    if (e_done[1:0] != 2'b00) chk("m_rdata", bus.rdata, e_rdata);
  endtask

  int nce, nwe, ndone, n;
  logic [2:0] got [5];
  logic [2:0] exp_order [5];

  initial begin
`ifdef LOBSTER_DBUS_RR_EN
    exp_order = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010};
`else
    exp_order = '{3'b100, 3'b100, 3'b100, 3'b100, 3'b100};
`endif
    bus.req = '0; bus.addr_f = '0; bus.addr_l = '0; bus.addr_s = '0;
    bus.wdata_s = '0; bus.data_in = '0; bus.rdy = 1'b0;
    rst = 1'b1;
    step(); step();
    chk("rst_ce", 64'(bus.ce), 64'd0);
    chk("rst_done", 64'(bus.done), 64'd0);
    chk("rst_rdata", bus.rdata, 64'd0);
    rst = 1'b0;
    step();

    // Load, rdy already high in IDLE/ISSUE (must be ignored there)
    bus.req = 3'b010; bus.addr_l = 36'h100; bus.data_in = 64'hDEAD; bus.rdy = 1'b1;
    step();
    chk("t1_ce_issue", 64'(bus.ce), 64'd1);
    chk("t1_addr", 64'(bus.addr_in), 64'h100);
    chk("t1_done_c1", 64'(bus.done), 64'd0);
    step();
    chk("t1_done_c2", 64'(bus.done), 64'd0);
    chk("t1_we_c2", 64'(bus.we), 64'd0);
    step();
    chk("t1_done_c3", 64'(bus.done), 64'b010);
    chk("t1_rdata", bus.rdata, 64'hDEAD);
    bus.req = 3'b000; bus.rdy = 1'b0;
    step();
    chk("t1_done_after", 64'(bus.done), 64'd0);

    // Store, rdy on the fourth WAIT cycle
    bus.req = 3'b100; bus.addr_s = 36'h200; bus.wdata_s = 64'h55;
    nce = 0; nwe = 0; ndone = 0;
    for (int i = 1; i <= 7; i++) begin
      step();
      if (bus.ce === 1'b1) nce++;
      if (bus.we === 1'b1) nwe++;
      if (bus.done[2] === 1'b1) ndone++;
      if (i == 3) chk("t2_dout", bus.data_out, 64'h55);
      if (i == 5) bus.rdy = 1'b1;
      if (i == 6) begin bus.rdy = 1'b0; bus.req = 3'b000; end
    end
    chk("t2_ce_cycles", 64'(nce), 64'd5);
    chk("t2_we_cycles", 64'(nwe), 64'd5);
    chk("t2_done_count", 64'(ndone), 64'd1);

    // All three requesting, held
    bus.req = 3'b111; bus.addr_f = 36'h10; bus.addr_l = 36'h20; bus.addr_s = 36'h30;
    bus.rdy = 1'b1;
    n = 0;
    for (int i = 0; i < 14 && n < 4; i++) begin
      step();
      if (bus.done != 3'b000) begin got[n] = bus.done; n++; end
    end
    chk("t3_ngrants", 64'(n), 64'd4);
    step();
    bus.req = 3'b000;
    ndone = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (bus.done != 3'b000) begin got[4] = bus.done; ndone++; end
    end
    chk("t3_drop_still_done", 64'(ndone), 64'd1);
    bus.rdy = 1'b0;
    for (int k = 0; k < 5; k++) chk($sformatf("t3_order%0d", k), 64'(got[k]), 64'(exp_order[k]));

    // Timeout on a fetch
    bus.req = 3'b001; bus.addr_f = 36'h300; bus.data_in = 64'hBEEF;
    for (int i = 1; i <= 7; i++) begin
      step();
      if (i == 5) chk("t4_no_early_done", 64'(bus.done), 64'd0);
      if (i == 6) begin
        chk("t4_done", 64'(bus.done), 64'b001);
        chk("t4_err", 64'(bus.err), 64'd1);
        chk("t4_rdata", bus.rdata, 64'd0);
        chk("t4_ce_off", 64'(bus.ce), 64'd0);
        bus.req = 3'b000;
      end
      if (i == 7) chk("t4_err_pulse", 64'(bus.err), 64'd0);
    end

    // Reset in the middle of WAIT
    bus.req = 3'b010; bus.addr_l = 36'h400;
    step(); step(); step();
    rst = 1'b1;
    step();
    chk("t5_ce", 64'(bus.ce), 64'd0);
    chk("t5_done", 64'(bus.done), 64'd0);
    rst = 1'b0; bus.req = 3'b000;
    step();
    bus.rdy = 1'b1;
    step(); step();
    chk("t5_no_done", 64'(bus.done), 64'd0);
    bus.rdy = 1'b0;
    step();

    // Fresh transaction after reset behaves from IDLE
    bus.req = 3'b001; bus.addr_f = 36'h500; bus.data_in = 64'h1234; bus.rdy = 1'b1;
    step(); step(); step();
    chk("t6_done", 64'(bus.done), 64'b001);
    chk("t6_rdata", bus.rdata, 64'h1234);
    bus.req = 3'b000; bus.rdy = 1'b0;
    step(); step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/lobster_dbus_arbiter.md
LOBSTER_DBUS_ARBITER -- requirements
Module: lobster_dbus_arbiter

Interface
REQ-001 Parameter ADDR_WIDTH, default 36, SHALL set the SRAM address width.
REQ-002 Parameter TIMEOUT, default 255, SHALL set the maximum number of WAIT cycles without rdy before abort; legal range 1..65535.
REQ-003 clk  in  1  clock; all logic on posedge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 req  in  3  request per port; [0]=fetch, [1]=load, [2]=store.
REQ-006 addr_f, addr_l, addr_s  in  ADDR_WIDTH each  per-port address.
REQ-007 wdata_s  in  64  store data.
REQ-008 done  out  3  one-cycle completion pulse per port.
REQ-009 err  out  1  one-cycle pulse coincident with done on timeout abort.
REQ-010 rdata  out  64  read data, valid while done[0] or done[1] is high.
REQ-011 ce, we  out  1 each  SRAM command-enable and write-enable.
REQ-012 addr_in, addr_out  out  ADDR_WIDTH each  SRAM read and write address.
REQ-013 data_out  out  64  SRAM write data.
REQ-014 data_in  in  64  SRAM read data; rdy  in  1  SRAM ready.

Function
REQ-015 The FSM SHALL have three states: IDLE, ISSUE and WAIT.
REQ-016 In IDLE with any req bit set, the arbiter SHALL register the winner's index, address and data and move to ISSUE; otherwise it SHALL remain in IDLE.
REQ-017 In ISSUE, ce SHALL be 1, we SHALL be 1 only for the store port, addr_in/addr_out SHALL drive the latched address, and the FSM SHALL move to WAIT.
REQ-018 In WAIT, ce, we, addresses and data_out SHALL hold; rdy=1 SHALL capture data_in into rdata (reads only), pulse done[winner], drop ce/we and return to IDLE.
REQ-019 Minimum latency from req to done SHALL be 3 cycles (IDLE, ISSUE, first WAIT with rdy); back-to-back transactions SHALL be separated by one IDLE cycle.
REQ-020 rdy seen in IDLE or ISSUE SHALL be ignored.
REQ-021 A wait counter SHALL clear on entry to WAIT; after TIMEOUT WAIT cycles with rdy=0, the arbiter SHALL pulse done[winner] and err, drop ce/we, and return to IDLE. rdata SHALL then read 0.
REQ-022 Requesters SHALL hold req and operands until done. Deasserting req mid-transaction SHALL NOT abort it; done SHALL still pulse.
REQ-023 A req bit that is still high in the cycle after its done pulse SHALL be treated as a new request.
REQ-024 Fixed priority SHALL be store > load > fetch when the round-robin feature is absent.
REQ-025 Outputs done, err, ce and we SHALL be 0 in every state not listed above.

Reset
REQ-026 On rst, the FSM SHALL enter IDLE and ce, we, done, err, rdata, addr_in, addr_out, data_out and the wait counter SHALL be 0, including when reset occurs mid-WAIT.
REQ-027 The round-robin pointer SHALL reset so that fetch has highest priority for the first grant.

Configuration
REQ-028 With macro LOBSTER_DBUS_RR_EN defined, arbitration SHALL be round-robin: the search starts at the port after the last granted port and wraps 2 to 0. The pointer SHALL update on every completion, including timeout.
REQ-029 Without LOBSTER_DBUS_RR_EN, fixed priority per REQ-024 SHALL apply and no pointer register SHALL exist.

Structure
REQ-030 Port index localparams (PORT_FETCH=0, PORT_LOAD=1, PORT_STORE=2) and the FSM state enum typedef SHALL live in shared package lobster_pkg.
REQ-031 Winner selection SHALL be a combinational sub-module lobster_dbus_pick (inputs req and pointer, output one-hot grant).

Verification
REQ-032 Load only: req=3'b010, addr_l=0x100, rdy high on the first WAIT cycle, data_in=0xDEAD -> done=3'b010 at cycle 3, rdata=0xDEAD, we=0 throughout.
REQ-033 Store only: req=3'b100, wdata_s=0x55, rdy after 4 WAIT cycles -> we=1 and ce=1 for 5 cycles, data_out=0x55, done[2] pulses once.
REQ-034 Fixed priority, all three requesting: req=3'b111 held -> grant order store, store, ...; with LOBSTER_DBUS_RR_EN, order fetch, load, store, fetch.
REQ-035 Timeout: TIMEOUT=4, rdy held 0 -> done and err pulse together after 4 WAIT cycles, ce=0 the next cycle, rdata=0.
REQ-036 Reset mid-WAIT: rst asserted during WAIT -> ce=0 and done=0 the next cycle, FSM in IDLE; a later rdy pulse produces no done.
